// File: rtl/vector_load_sequencer.sv
// vector_load_sequencer
// Takes one vector-load request from decode (word or short vector), issues
// 1/2/4 element reads to data memory, and writes each returned element into
// the WVR or SVR register file. Holds the pipeline stall line high while busy.
//
// Handshake: a memory read transfers in the cycle where mem_rd_en_o and
// mem_gnt_i are both high. While grant is low, the address and the element
// index are held. Read data arrives exactly one cycle after the transfer and
// is written into the register file in that same cycle (vrf_we_o high).
module vector_load_sequencer #(
    parameter int XLEN  = 32,
    parameter int NVREG = 8,
    parameter int REG_W = $clog2(NVREG)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wvr_load_i,
    input  logic             svr_load_i,
    input  logic [1:0]       vl_i,
    input  logic [XLEN-1:0]  base_addr_i,
    input  logic [REG_W-1:0] vreg_dst_i,
    output logic             stall_o,
    output logic             done_o,
    output logic             err_o,
    output logic             mem_rd_en_o,
    output logic [XLEN-1:0]  mem_addr_o,
    input  logic             mem_gnt_i,
    input  logic [XLEN-1:0]  mem_rdata_i,
    output logic             vrf_we_o,
    output logic             vrf_sel_o,
    output logic [REG_W-1:0] vrf_idx_o,
    output logic [1:0]       vrf_lane_o,
    output logic [XLEN-1:0]  vrf_wdata_o,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           state_q;
    logic             stall_q;
    logic             done_q;
    logic             err_q;
    logic             rd_en_q;
    logic [XLEN-1:0]  addr_q;
    logic [XLEN-1:0]  addr_d;
    logic [1:0]       i_q;
    logic [1:0]       i_d;
    logic [1:0]       n_last_q;
    logic [1:0]       n_last_d;
    logic             svr_q;
    logic [REG_W-1:0] dst_q;

    // Writeback-stage registers describing the element arriving this cycle
    logic             we_q;
    logic             sel_q;
    logic [REG_W-1:0] idx_q;
    logic [1:0]       lane_q;
    logic             hi_q;

    logic             req;
    logic             req_svr;
    logic             req_bad;
    logic             rd_accept;
    logic             last_read;
    logic [XLEN-1:0]  stride;

    // Request decode, reject rules and issue-side next values
    always_comb begin
        req       = wvr_load_i | svr_load_i;
        // WVR wins when both request lines are high
        req_svr   = svr_load_i & ~wvr_load_i;
        req_bad   = (vl_i == 2'b11) ||
                    (req_svr ? base_addr_i[0] : (base_addr_i[1:0] != 2'b00));
        rd_accept = rd_en_q & mem_gnt_i;
        last_read = (i_q == n_last_q);
        stride    = svr_q ? XLEN'(2) : XLEN'(4);
        addr_d    = addr_q + stride;
        i_d       = i_q + 2'd1;
        case (vl_i)
            2'b00:   n_last_d = 2'd0;
            2'b01:   n_last_d = 2'd1;
            default: n_last_d = 2'd3;
        endcase
    end

    // Sequencer FSM with registered outputs; writeback tracks accepted reads
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            stall_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rd_en_q  <= 1'b0;
            addr_q   <= '0;
            i_q      <= '0;
            n_last_q <= '0;
            svr_q    <= 1'b0;
            dst_q    <= '0;
            we_q     <= 1'b0;
            sel_q    <= 1'b0;
            idx_q    <= '0;
            lane_q   <= '0;
            hi_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            we_q   <= rd_accept;
            if (rd_accept) begin
                lane_q <= i_q;
                hi_q   <= addr_q[1];
                idx_q  <= dst_q;
                sel_q  <= svr_q;
            end

            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        if (req_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q  <= S_ISSUE;
                            stall_q  <= 1'b1;
                            rd_en_q  <= 1'b1;
                            svr_q    <= req_svr;
                            dst_q    <= vreg_dst_i;
                            addr_q   <= base_addr_i;
                            i_q      <= 2'd0;
                            n_last_q <= n_last_d;
                        end
                    end
                end
                S_ISSUE: begin
                    if (rd_accept) begin
                        if (last_read) begin
                            // Final element lands next cycle, in DRAIN
                            state_q <= S_DRAIN;
                            rd_en_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            addr_q <= addr_d;
                            i_q    <= i_d;
                        end
                    end
                end
                S_DRAIN: begin
                    state_q <= S_IDLE;
                    stall_q <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    stall_q <= 1'b0;
                    rd_en_q <= 1'b0;
                end
            endcase
        end
    end

    // Element data: word passes through, short takes the addressed half
    always_comb begin
        vrf_wdata_o = '0;
        if (we_q) begin
            if (sel_q) begin
                vrf_wdata_o = {{(XLEN-16){1'b0}},
                               (hi_q ? mem_rdata_i[31:16] : mem_rdata_i[15:0])};
            end else begin
                vrf_wdata_o = mem_rdata_i;
            end
        end
    end

    assign stall_o     = stall_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign mem_rd_en_o = rd_en_q;
    assign mem_addr_o  = addr_q;
    assign vrf_we_o    = we_q;
    assign vrf_sel_o   = sel_q;
    assign vrf_idx_o   = idx_q;
    assign vrf_lane_o  = lane_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_vector_load_sequencer.sv
// Directed bench for vector_load_sequencer: word/short loads, grant stalls,
// rejects, address wrap, mid-operation reset and back-to-back requests.
module tb_vector_load_sequencer;

    logic        clk;
    logic        rst;
    logic        wvr_load;
    logic        svr_load;
    logic [1:0]  vl;
    logic [31:0] base_addr;
    logic [2:0]  vreg_dst;
    logic        stall;
    logic        done;
    logic        err;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic [31:0] mem_rdata;
    logic        vrf_we;
    logic        vrf_sel;
    logic [2:0]  vrf_idx;
    logic [1:0]  vrf_lane;
    logic [31:0] vrf_wdata;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;

    vector_load_sequencer #(.XLEN(32), .NVREG(8), .REG_W(3)) dut (
        .clk_i(clk), .rst_i(rst),
        .wvr_load_i(wvr_load), .svr_load_i(svr_load), .vl_i(vl),
        .base_addr_i(base_addr), .vreg_dst_i(vreg_dst),
        .stall_o(stall), .done_o(done), .err_o(err),
        .mem_rd_en_o(mem_rd_en), .mem_addr_o(mem_addr),
        .mem_gnt_i(mem_gnt), .mem_rdata_i(mem_rdata),
        .vrf_we_o(vrf_we), .vrf_sel_o(vrf_sel), .vrf_idx_o(vrf_idx),
        .vrf_lane_o(vrf_lane), .vrf_wdata_o(vrf_wdata),
        .dbg_state_o(dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents as seen at word-aligned addresses
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w == 32'h0000_0200)      return 32'hAAAA_BBBB;
        else if (w == 32'h0000_0204) return 32'hCCCC_DDDD;
        else                         return {~w[15:0], w[15:0]};
    endfunction

    // Memory: data for an accepted read appears the next cycle
    always @(posedge clk) begin
        if (mem_rd_en && mem_gnt) mem_rdata <= mem_word(mem_addr);
        else                      mem_rdata <= 32'hDEAD_BEEF;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present a request during cycle 0; returns early in cycle 1 with loads cleared
    task automatic start_req(input logic w, input logic s, input logic [1:0] v,
                             input logic [31:0] b, input logic [2:0] d);
        wvr_load = w; svr_load = s; vl = v; base_addr = b; vreg_dst = d;
        tick();
        wvr_load = 1'b0; svr_load = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; wvr_load = 0; svr_load = 0; vl = 0; base_addr = 0; vreg_dst = 0;
        mem_gnt = 1'b1;
        tick(); tick();
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", mem_rd_en); end
        checks++; if (vrf_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", vrf_we); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", mem_addr); end
        checks++; if ({vrf_sel, vrf_idx, vrf_lane} !== 6'h0) begin errors++; $display("FAIL reset_vrf_ctl: got %h expected 0", {vrf_sel, vrf_idx, vrf_lane}); end
        checks++; if (vrf_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", vrf_wdata); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_wvr4;
        logic e_stall, e_rd, e_we, e_done;
        logic [31:0] e_data;
        start_req(1, 0, 2'b10, 32'h0000_0100, 3'd5);
        for (int c = 1; c <= 6; c++) begin
            #1;
            e_stall = (c <= 5); e_rd = (c <= 4); e_we = (c >= 2 && c <= 5); e_done = (c == 5);
            checks++; if (stall !== e_stall) begin errors++; $display("FAIL wvr4_stall c%0d: got %b expected %b", c, stall, e_stall); end
            checks++; if (mem_rd_en !== e_rd) begin errors++; $display("FAIL wvr4_rd_en c%0d: got %b expected %b", c, mem_rd_en, e_rd); end
            checks++; if (vrf_we !== e_we) begin errors++; $display("FAIL wvr4_we c%0d: got %b expected %b", c, vrf_we, e_we); end
            checks++; if (done !== e_done) begin errors++; $display("FAIL wvr4_done c%0d: got %b expected %b", c, done, e_done); end
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL wvr4_err c%0d: got %b expected 0", c, err); end
            if (e_rd) begin
                checks++; if (mem_addr !== 32'h100 + 32'(4 * (c - 1))) begin errors++; $display("FAIL wvr4_addr c%0d: got %h expected %h", c, mem_addr, 32'h100 + 32'(4 * (c - 1))); end
            end
            if (e_we) begin
                e_data = mem_word(32'h100 + 32'(4 * (c - 2)));
                checks++; if (vrf_lane !== 2'(c - 2)) begin errors++; $display("FAIL wvr4_lane c%0d: got %0d expected %0d", c, vrf_lane, c - 2); end
                checks++; if (vrf_idx !== 3'd5 || vrf_sel !== 1'b0) begin errors++; $display("FAIL wvr4_idx_sel c%0d: got %0d/%b expected 5/0", c, vrf_idx, vrf_sel); end
                checks++; if (vrf_wdata !== e_data) begin errors++; $display("FAIL wvr4_wdata c%0d: got %h expected %h", c, vrf_wdata, e_data); end
            end
            tick();
        end
    endtask

    task automatic test_svr2;
        logic [31:0] e_data;
        start_req(0, 1, 2'b01, 32'h0000_0202, 3'd3);
        for (int c = 1; c <= 4; c++) begin
            #1;
            checks++; if (stall !== (c <= 3)) begin errors++; $display("FAIL svr2_stall c%0d: got %b expected %b", c, stall, (c <= 3)); end
            checks++; if (done !== (c == 3)) begin errors++; $display("FAIL svr2_done c%0d: got %b expected %b", c, done, (c == 3)); end
            checks++; if (vrf_we !== (c == 2 || c == 3)) begin errors++; $display("FAIL svr2_we c%0d: got %b expected %b", c, vrf_we, (c == 2 || c == 3)); end
            if (c <= 2) begin
                checks++; if (mem_addr !== 32'h202 + 32'(2 * (c - 1))) begin errors++; $display("FAIL svr2_addr c%0d: got %h expected %h", c, mem_addr, 32'h202 + 32'(2 * (c - 1))); end
            end
            if (c == 2 || c == 3) begin
                e_data = (c == 2) ? 32'h0000_AAAA : 32'h0000_DDDD;
                checks++; if (vrf_wdata !== e_data) begin errors++; $display("FAIL svr2_wdata c%0d: got %h expected %h", c, vrf_wdata, e_data); end
                checks++; if (vrf_sel !== 1'b1 || vrf_idx !== 3'd3 || vrf_lane !== 2'(c - 2)) begin errors++; $display("FAIL svr2_ctl c%0d: got %b/%0d/%0d expected 1/3/%0d", c, vrf_sel, vrf_idx, vrf_lane, c - 2); end
            end
            tick();
        end
    endtask

    task automatic test_gnt_stall;
        logic [31:0] e_data;
        start_req(1, 0, 2'b01, 32'h0000_0300, 3'd1);
        for (int c = 1; c <= 6; c++) begin
            mem_gnt = (c >= 3);
            #1;
            checks++; if (mem_rd_en !== (c <= 4)) begin errors++; $display("FAIL gnt_rd_en c%0d: got %b expected %b", c, mem_rd_en, (c <= 4)); end
            checks++; if (vrf_we !== (c == 4 || c == 5)) begin errors++; $display("FAIL gnt_we c%0d: got %b expected %b", c, vrf_we, (c == 4 || c == 5)); end
            checks++; if (done !== (c == 5)) begin errors++; $display("FAIL gnt_done c%0d: got %b expected %b", c, done, (c == 5)); end
            checks++; if (stall !== (c <= 5)) begin errors++; $display("FAIL gnt_stall c%0d: got %b expected %b", c, stall, (c <= 5)); end
            if (c <= 4) begin
                checks++; if (mem_addr !== ((c <= 3) ? 32'h300 : 32'h304)) begin errors++; $display("FAIL gnt_addr c%0d: got %h expected %h", c, mem_addr, ((c <= 3) ? 32'h300 : 32'h304)); end
            end
            if (c == 4 || c == 5) begin
                e_data = mem_word(32'h300 + 32'(4 * (c - 4)));
                checks++; if (vrf_wdata !== e_data || vrf_lane !== 2'(c - 4)) begin errors++; $display("FAIL gnt_write c%0d: got %h/%0d expected %h/%0d", c, vrf_wdata, vrf_lane, e_data, c - 4); end
            end
            tick();
        end
        mem_gnt = 1'b1;
    endtask

    task automatic test_reject;
        logic [1:0]  rv[3];
        logic [31:0] rb[3];
        logic        rs[3];
        rv[0] = 2'b11; rb[0] = 32'h100; rs[0] = 1'b0;
        rv[1] = 2'b00; rb[1] = 32'h102; rs[1] = 1'b0;
        rv[2] = 2'b01; rb[2] = 32'h201; rs[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            start_req(!rs[k], rs[k], rv[k], rb[k], 3'd2);
            for (int c = 1; c <= 3; c++) begin
                #1;
                checks++; if (err !== (c == 1)) begin errors++; $display("FAIL reject%0d_err c%0d: got %b expected %b", k, c, err, (c == 1)); end
                checks++; if ({stall, mem_rd_en, vrf_we, done} !== 4'b0) begin errors++; $display("FAIL reject%0d_quiet c%0d: got %b expected 0000", k, c, {stall, mem_rd_en, vrf_we, done}); end
                tick();
            end
        end
    endtask

    task automatic test_wrap;
        start_req(1, 0, 2'b01, 32'hFFFF_FFFC, 3'd7);
        #1;
        checks++; if (mem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr0: got %h expected fffffffc", mem_addr); end
        tick(); #1;
        checks++; if (mem_addr !== 32'h0000_0000 || mem_rd_en !== 1'b1) begin errors++; $display("FAIL wrap_addr1: got %h/%b expected 00000000/1", mem_addr, mem_rd_en); end
        checks++; if (vrf_wdata !== mem_word(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap_wdata0: got %h expected %h", vrf_wdata, mem_word(32'hFFFF_FFFC)); end
        tick(); #1;
        checks++; if (vrf_wdata !== mem_word(32'h0) || done !== 1'b1) begin errors++; $display("FAIL wrap_wdata1: got %h/%b expected %h/1", vrf_wdata, done, mem_word(32'h0)); end
        tick(); tick();
    endtask

    task automatic test_reset_mid;
        start_req(1, 0, 2'b10, 32'h0000_0100, 3'd4);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++; if ({stall, vrf_we, done, mem_rd_en} !== 4'b0) begin errors++; $display("FAIL rstmid_c3: got %b expected 0000", {stall, vrf_we, done, mem_rd_en}); end
        tick(); #1;
        checks++; if ({stall, vrf_we, done, mem_rd_en} !== 4'b0) begin errors++; $display("FAIL rstmid_c4: got %b expected 0000", {stall, vrf_we, done, mem_rd_en}); end
        start_req(1, 0, 2'b00, 32'h0000_0140, 3'd6);
        #1;
        checks++; if (stall !== 1'b1 || mem_addr !== 32'h140) begin errors++; $display("FAIL rstmid_new: got %b/%h expected 1/00000140", stall, mem_addr); end
        tick(); #1;
        checks++; if (vrf_we !== 1'b1 || done !== 1'b1 || vrf_lane !== 2'd0 || vrf_idx !== 3'd6) begin errors++; $display("FAIL rstmid_new_wr: got %b/%b/%0d/%0d expected 1/1/0/6", vrf_we, done, vrf_lane, vrf_idx); end
        tick(); tick();
    endtask

    task automatic test_back_to_back;
        // Both lines high: word load wins, loads held high while busy are ignored
        wvr_load = 1'b1; svr_load = 1'b1; vl = 2'b00; base_addr = 32'h400; vreg_dst = 3'd2;
        tick();
        base_addr = 32'h600;
        #1;
        checks++; if (mem_addr !== 32'h400 || stall !== 1'b1) begin errors++; $display("FAIL b2b_issue: got %h/%b expected 00000400/1", mem_addr, stall); end
        tick(); #1;
        checks++; if (vrf_sel !== 1'b0 || vrf_wdata !== mem_word(32'h400) || done !== 1'b1) begin errors++; $display("FAIL b2b_write: got %b/%h/%b expected 0/%h/1", vrf_sel, vrf_wdata, done, mem_word(32'h400)); end
        tick();
        wvr_load = 1'b0; svr_load = 1'b0;
        #1;
        checks++; if ({stall, mem_rd_en, vrf_we, err} !== 4'b0) begin errors++; $display("FAIL b2b_ignored: got %b expected 0000", {stall, mem_rd_en, vrf_we, err}); end
        start_req(0, 1, 2'b00, 32'h0000_0700, 3'd1);
        #1;
        checks++; if (mem_addr !== 32'h700 || mem_rd_en !== 1'b1) begin errors++; $display("FAIL b2b_second_issue: got %h/%b expected 00000700/1", mem_addr, mem_rd_en); end
        tick(); #1;
        checks++; if (vrf_wdata !== {16'h0, mem_word(32'h700) & 32'h0000_FFFF} || vrf_sel !== 1'b1) begin errors++; $display("FAIL b2b_second_write: got %h/%b expected %h/1", vrf_wdata, vrf_sel, mem_word(32'h700) & 32'h0000_FFFF); end
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_wvr4();
        test_svr2();
        test_gnt_stall();
        test_reject();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
